// File: rtl/hb_decim_fir_prog.sv
// rtl/hb_decim_fir_prog.sv - half-band decimate-by-2 I/Q FIR with programmable symmetric taps
//
// Purpose: decimates an I/Q stream by two through a half-band FIR of NUM_TAPS = 4k+3 taps.
// Even taps are programmable in mirrored pairs. Odd taps are zero, except the centre tap, which is
// fixed at 0.5. The result is rounded half up and saturated to WIDTH bits. Bypass mode emits the
// even sample of each pair unfiltered, with the same latency as filter mode.
//
// Ports:
//   i_clock, i_reset         clock and synchronous active-high reset
//   i_inph_data/i_quad_data  signed input samples, qualified by i_valid (no backpressure)
//   i_bypass                 sampled with the odd sample of each pair; 1 = decimate only
//   i_coef_wr/addr/data      write unique tap j (taps 2j and NUM_TAPS-1-2j)
//   o_inph_data/o_quad_data  signed outputs, held between o_valid pulses
//   o_valid                  one-cycle strobe, 3 clocks after the odd sample is accepted
module hb_decim_fir_prog #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 18,
  parameter int NUM_TAPS   = 11,
  parameter int NUM_UNIQ   = (NUM_TAPS + 1) / 4,
  parameter int ADDR_WIDTH = (NUM_UNIQ > 1) ? $clog2(NUM_UNIQ) : 1
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic signed [WIDTH-1:0]      i_inph_data,
  input  logic signed [WIDTH-1:0]      i_quad_data,
  input  logic                         i_valid,
  input  logic                         i_bypass,
  input  logic                         i_coef_wr,
  input  logic        [ADDR_WIDTH-1:0] i_coef_addr,
  input  logic signed [COEF_WIDTH-1:0] i_coef_data,
  output logic signed [WIDTH-1:0]      o_inph_data,
  output logic signed [WIDTH-1:0]      o_quad_data,
  output logic                         o_valid
);
  localparam int CENTER = (NUM_TAPS - 1) / 2;
  localparam int PRE_W  = WIDTH + 1;
  localparam int PROD_W = PRE_W + COEF_WIDTH;
  localparam int ACC_W  = WIDTH + COEF_WIDTH + $clog2(NUM_TAPS) + 1;
  localparam int SHIFT  = COEF_WIDTH - 1;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (COEF_WIDTH - 2);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  if ((NUM_TAPS % 4) != 3 || NUM_UNIQ != (NUM_TAPS + 1) / 4) begin : g_bad_taps
    $error("hb_decim_fir_prog: NUM_TAPS must be 4k+3");
  end

  logic signed [WIDTH-1:0]      dl_i [NUM_TAPS];
  logic signed [WIDTH-1:0]      dl_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] coef      [NUM_UNIQ];
  logic signed [COEF_WIDTH-1:0] coef_snap [NUM_UNIQ];
  logic                         phase, launch, vld1, vld2, byp0, byp1;
  logic signed [PRE_W-1:0]      pre_i  [NUM_UNIQ];
  logic signed [PRE_W-1:0]      pre_q  [NUM_UNIQ];
  logic signed [PROD_W-1:0]     mul_i  [NUM_UNIQ];
  logic signed [PROD_W-1:0]     mul_q  [NUM_UNIQ];
  logic signed [PROD_W-1:0]     prod_i [NUM_UNIQ];
  logic signed [PROD_W-1:0]     prod_q [NUM_UNIQ];
  logic signed [WIDTH-1:0]      ctr_i, ctr_q, byp_i, byp_q;
  logic signed [ACC_W-1:0]      sum_i, sum_q, acc_i, acc_q;

  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = (a + HALF) >>> SHIFT;
    if (r > MAXV)      return MAXV[WIDTH-1:0];
    else if (r < MINV) return MINV[WIDTH-1:0];
    else               return r[WIDTH-1:0];
  endfunction

  // Input side: delay lines, phase bit, coefficient registers. The coefficient set is snapshotted
  // at the launching edge so that a write on that same edge affects only later computations.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      phase  <= 1'b0;
      launch <= 1'b0;
      byp0   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        dl_i[k] <= '0;
        dl_q[k] <= '0;
      end
      for (int j = 0; j < NUM_UNIQ; j++) begin
        coef[j]      <= '0;
        coef_snap[j] <= '0;
      end
    end else begin
      launch <= i_valid && phase;
      if (i_valid) begin
        phase   <= ~phase;
        dl_i[0] <= i_inph_data;
        dl_q[0] <= i_quad_data;
        for (int k = 1; k < NUM_TAPS; k++) begin
          dl_i[k] <= dl_i[k-1];
          dl_q[k] <= dl_q[k-1];
        end
        if (phase) begin
          byp0 <= i_bypass;
          for (int j = 0; j < NUM_UNIQ; j++) coef_snap[j] <= coef[j];
        end
      end
      // Addresses >= NUM_UNIQ match no register and are dropped.
      for (int j = 0; j < NUM_UNIQ; j++) begin
        if (i_coef_wr && i_coef_addr == ADDR_WIDTH'(j)) coef[j] <= i_coef_data;
      end
    end
  end

  // Symmetric pre-add: tap 2j and its mirror share a coefficient.
  always_comb begin
    for (int j = 0; j < NUM_UNIQ; j++) begin
      pre_i[j] = PRE_W'(dl_i[2*j]) + PRE_W'(dl_i[NUM_TAPS-1-2*j]);
      pre_q[j] = PRE_W'(dl_q[2*j]) + PRE_W'(dl_q[NUM_TAPS-1-2*j]);
      mul_i[j] = PROD_W'(pre_i[j]) * PROD_W'(coef_snap[j]);
      mul_q[j] = PROD_W'(pre_q[j]) * PROD_W'(coef_snap[j]);
    end
  end

  // Centre tap of 0.5 is a plain shift into the accumulator's Q format.
  always_comb begin
    sum_i = ACC_W'(ctr_i) <<< (COEF_WIDTH - 2);
    sum_q = ACC_W'(ctr_q) <<< (COEF_WIDTH - 2);
    for (int j = 0; j < NUM_UNIQ; j++) begin
      sum_i = sum_i + ACC_W'(prod_i[j]);
      sum_q = sum_q + ACC_W'(prod_q[j]);
    end
  end

  // Three-stage pipeline: multiply, accumulate, round/saturate.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld1        <= 1'b0;
      vld2        <= 1'b0;
      o_valid     <= 1'b0;
      byp1        <= 1'b0;
      ctr_i       <= '0;
      ctr_q       <= '0;
      byp_i       <= '0;
      byp_q       <= '0;
      acc_i       <= '0;
      acc_q       <= '0;
      o_inph_data <= '0;
      o_quad_data <= '0;
      for (int j = 0; j < NUM_UNIQ; j++) begin
        prod_i[j] <= '0;
        prod_q[j] <= '0;
      end
    end else begin
      vld1    <= launch;
      vld2    <= vld1;
      o_valid <= vld2;
      if (launch) begin
        for (int j = 0; j < NUM_UNIQ; j++) begin
          prod_i[j] <= mul_i[j];
          prod_q[j] <= mul_q[j];
        end
        ctr_i <= dl_i[CENTER];
        ctr_q <= dl_q[CENTER];
        byp_i <= dl_i[1];
        byp_q <= dl_q[1];
        byp1  <= byp0;
      end
      // Bypass pre-scales the even sample so the shared rounding stage returns it unchanged.
      if (vld1) begin
        acc_i <= byp1 ? (ACC_W'(byp_i) <<< SHIFT) : sum_i;
        acc_q <= byp1 ? (ACC_W'(byp_q) <<< SHIFT) : sum_q;
      end
      if (vld2) begin
        o_inph_data <= round_sat(acc_i);
        o_quad_data <= round_sat(acc_q);
      end
    end
  end
endmodule

// File: tb/tb_hb_decim_fir_prog.sv
// tb/tb_hb_decim_fir_prog.sv - self-checking bench for hb_decim_fir_prog against a convolution model
module tb_hb_decim_fir_prog;
  localparam int W   = 16;
  localparam int CW  = 18;
  localparam int NT  = 11;
  localparam int NU  = 3;
  localparam int AW  = 2;
  localparam int CTR = (NT - 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1, valid = 1'b0, byp = 1'b0, cwr = 1'b0;
  logic signed [W-1:0]  xi = '0, xq = '0;
  logic [AW-1:0]        caddr = '0;
  logic signed [CW-1:0] cdata = '0;
  logic signed [W-1:0]  yi, yq;
  logic                 ov;

  hb_decim_fir_prog #(.WIDTH(W), .COEF_WIDTH(CW), .NUM_TAPS(NT)) dut (
    .i_clock(clk), .i_reset(rst), .i_inph_data(xi), .i_quad_data(xq), .i_valid(valid),
    .i_bypass(byp), .i_coef_wr(cwr), .i_coef_addr(caddr), .i_coef_data(cdata),
    .o_inph_data(yi), .o_quad_data(yq), .o_valid(ov)
  );

  int checks = 0;
  int errors = 0;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int obs_e[$], obs_i[$], obs_q[$];
  int exp_e[$], exp_i[$], exp_q[$];
  int hold_bad = 0;
  logic signed [W-1:0] last_i = '0, last_q = '0;

  always @(negedge clk) begin
    if (ov === 1'b1) begin
      obs_e.push_back(edge_cnt);
      obs_i.push_back(int'(yi));
      obs_q.push_back(int'(yq));
    end
    if (rst === 1'b1) begin
      last_i <= '0;
      last_q <= '0;
    end else if (ov === 1'b1) begin
      last_i <= yi;
      last_q <= yq;
    end else if (yi !== last_i || yq !== last_q) begin
      hold_bad <= hold_bad + 1;
    end
  end

  int hist_i[$], hist_q[$];
  int mcoef[NU];

  // y[n] = sum_k h[k] * x[n-k], then round half up and saturate.
  function automatic int fir_ref(input bit use_q, input int n);
    longint acc, h, x;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      if (k == CTR)       h = longint'(1) <<< (CW - 2);
      else if (k % 2 == 1) h = 0;
      else if (k < CTR)   h = mcoef[k / 2];
      else                h = mcoef[(NT - 1 - k) / 2];
      if (n - k < 0) x = 0;
      else           x = use_q ? hist_q[n - k] : hist_i[n - k];
      acc += h * x;
    end
    acc = (acc + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
    if (acc > (1 << (W - 1)) - 1) acc = (1 << (W - 1)) - 1;
    if (acc < -(1 << (W - 1)))    acc = -(1 << (W - 1));
    return int'(acc);
  endfunction

  task automatic step(input bit r, input bit v, input int a, input int b, input bit bp,
                      input bit w, input int ad, input int d);
    int n, e;
    rst = r; valid = v; xi = W'(a); xq = W'(b); byp = bp;
    cwr = w; caddr = AW'(ad); cdata = CW'(d);
    @(posedge clk);
    #1;
    e = edge_cnt;
    if (r) begin
      hist_i.delete(); hist_q.delete();
      for (int j = 0; j < NU; j++) mcoef[j] = 0;
      while (exp_e.size() > 0 && exp_e[exp_e.size()-1] >= e) begin
        void'(exp_e.pop_back()); void'(exp_i.pop_back()); void'(exp_q.pop_back());
      end
    end else begin
      if (v) begin
        hist_i.push_back(a); hist_q.push_back(b);
        n = hist_i.size() - 1;
        if (n % 2 == 1) begin
          exp_e.push_back(e + 3);
          exp_i.push_back(bp ? hist_i[n-1] : fir_ref(1'b0, n));
          exp_q.push_back(bp ? hist_q[n-1] : fir_ref(1'b1, n));
        end
      end
      if (w && ad < NU) mcoef[ad] = d;
    end
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic restart();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    obs_e.delete(); obs_i.delete(); obs_q.delete();
    exp_e.delete(); exp_i.delete(); exp_q.delete();
  endtask

  function automatic int rnd_s(input int bits);
    return int'($urandom_range(0, (1 << bits) - 1)) - (1 << (bits - 1));
  endfunction

  task automatic test_reset();
    step(1, 1, 1234, -1234, 0, 1, 0, 5000);
    step(1, 1, 1234, -1234, 0, 1, 1, 5000);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ov); end
    checks++; if (yi !== '0) begin errors++; $display("FAIL reset_inph got %0d want 0", yi); end
    checks++; if (yq !== '0) begin errors++; $display("FAIL reset_quad got %0d want 0", yq); end
  endtask

  task automatic test_idle();
    int hb;
    restart();
    hb = hold_bad;
    idle(100);
    checks++; if (obs_e.size() !== 0) begin errors++; $display("FAIL idle_count got %0d want 0", obs_e.size()); end
    checks++; if (yi !== '0 || yq !== '0) begin errors++; $display("FAIL idle_out got %0d/%0d want 0/0", yi, yq); end
    checks++; if (hold_bad !== hb) begin errors++; $display("FAIL idle_hold got %0d want %0d", hold_bad, hb); end
  endtask

  task automatic test_impulse();
    restart();
    step(0, 0, 0, 0, 0, 1, 0, 4000);
    step(0, 0, 0, 0, 0, 1, 1, -8000);
    step(0, 0, 0, 0, 0, 1, 2, 20000);
    for (int n = 0; n < 16; n++) step(0, 1, (n == 1) ? 32767 : 0, (n == 1) ? -32767 : 0, 0, 0, 0, 0);
    idle(6);
    checks++; if (obs_e.size() !== 8) begin errors++; $display("FAIL impulse_count got %0d want 8", obs_e.size()); end
    for (int k = 0; k < exp_e.size() && k < obs_e.size(); k++) begin
      checks++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL impulse_out[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, obs_e[k], obs_i[k], obs_q[k], exp_e[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_center();
    int e5, nz, nz_val, nz_e;
    restart();
    for (int n = 0; n < 16; n++) begin
      step(0, 1, (n == 0) ? 16384 : 0, (n == 0) ? -16384 : 0, 0, 0, 0, 0);
      if (n == 5) e5 = edge_cnt;
    end
    idle(6);
    nz = 0; nz_val = 0; nz_e = 0;
    for (int k = 0; k < obs_e.size(); k++) if (obs_i[k] != 0) begin nz++; nz_val = obs_i[k]; nz_e = obs_e[k]; end
    checks++; if (nz !== 1) begin errors++; $display("FAIL center_nonzero got %0d want 1", nz); end
    checks++; if (nz_val !== 8192) begin errors++; $display("FAIL center_value got %0d want 8192", nz_val); end
    checks++; if (nz_e !== e5 + 3) begin errors++; $display("FAIL center_latency got edge %0d want %0d", nz_e, e5 + 3); end
    checks++; if (obs_e.size() !== exp_e.size()) begin errors++; $display("FAIL center_count got %0d want %0d", obs_e.size(), exp_e.size()); end
    for (int k = 0; k < exp_e.size() && k < obs_e.size(); k++) begin
      checks++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL center_out[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, obs_e[k], obs_i[k], obs_q[k], exp_e[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_saturation();
    restart();
    for (int j = 0; j < NU; j++) step(0, 0, 0, 0, 0, 1, j, 131071);
    for (int n = 0; n < 30; n++) step(0, 1, 32767, -32767, 0, 0, 0, 0);
    idle(6);
    checks++; if (obs_i[obs_i.size()-1] !== 32767 || obs_q[obs_q.size()-1] !== -32768) begin
      errors++; $display("FAIL sat_pos got %0d/%0d want 32767/-32768", obs_i[obs_i.size()-1], obs_q[obs_q.size()-1]);
    end
    for (int n = 0; n < 30; n++) step(0, 1, -32768, 32767, 0, 0, 0, 0);
    idle(6);
    checks++; if (obs_i[obs_i.size()-1] !== -32768 || obs_q[obs_q.size()-1] !== 32767) begin
      errors++; $display("FAIL sat_neg got %0d/%0d want -32768/32767", obs_i[obs_i.size()-1], obs_q[obs_q.size()-1]);
    end
    checks++; if (obs_e.size() !== exp_e.size()) begin errors++; $display("FAIL sat_count got %0d want %0d", obs_e.size(), exp_e.size()); end
    for (int k = 0; k < exp_e.size() && k < obs_e.size(); k++) begin
      checks++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL sat_out[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, obs_e[k], obs_i[k], obs_q[k], exp_e[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_bypass();
    int n, bad;
    restart();
    for (int j = 0; j < NU; j++) step(0, 0, 0, 0, 0, 1, j, rnd_s(CW));
    n = 0;
    while (n < 10000) begin
      if ($urandom_range(0, 1) == 1) begin step(0, 1, n, -n, 1, 0, 0, 0); n++; end
      else step(0, 0, 0, 0, 1, 0, 0, 0);
    end
    for (int k = 0; k < 40; k++) step(0, 1, rnd_s(W), rnd_s(W), 0, 0, 0, 0);
    idle(6);
    checks++; if (obs_e.size() !== 5020) begin errors++; $display("FAIL bypass_count got %0d want 5020", obs_e.size()); end
    bad = 0;
    for (int k = 0; k < 5000 && k < obs_i.size(); k++) begin
      checks++;
      if (obs_i[k] !== 2 * k || obs_q[k] !== -2 * k) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL bypass_ramp[%0d] got %0d/%0d want %0d/%0d", k, obs_i[k], obs_q[k], 2 * k, -2 * k);
      end
    end
    for (int k = 0; k < exp_e.size() && k < obs_e.size(); k++) begin
      checks++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL bypass_out[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, obs_e[k], obs_i[k], obs_q[k], exp_e[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    int hb;
    restart();
    hb = hold_bad;
    for (int c = 0; c < 600; c++) begin
      step(0, $urandom_range(0, 3) != 0, rnd_s(W), rnd_s(W), $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3), rnd_s(CW));
    end
    idle(6);
    checks++; if (hold_bad !== hb) begin errors++; $display("FAIL random_hold got %0d want %0d", hold_bad, hb); end
    checks++; if (obs_e.size() !== exp_e.size()) begin errors++; $display("FAIL random_count got %0d want %0d", obs_e.size(), exp_e.size()); end
    for (int k = 0; k < exp_e.size() && k < obs_e.size(); k++) begin
      checks++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL random_out[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, obs_e[k], obs_i[k], obs_q[k], exp_e[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    restart();
    for (int j = 0; j < NU; j++) step(0, 0, 0, 0, 0, 1, j, rnd_s(CW));
    for (int n = 0; n < 6; n++) step(0, 1, 1000 + n, -1000 - n, 0, 0, 0, 0);
    step(1, 1, 20000, -20000, 0, 1, 0, 60000);
    step(0, 1, 12345, -12345, 0, 0, 0, 0);
    step(0, 1, 23456, -23456, 0, 0, 0, 0);
    idle(6);
    checks++; if (obs_e.size() !== 2) begin errors++; $display("FAIL reset_mid_count got %0d want 2", obs_e.size()); end
    checks++; if (obs_i[obs_i.size()-1] !== 0 || obs_q[obs_q.size()-1] !== 0) begin
      errors++; $display("FAIL reset_mid_zero got %0d/%0d want 0/0", obs_i[obs_i.size()-1], obs_q[obs_q.size()-1]);
    end
    for (int k = 0; k < exp_e.size() && k < obs_e.size(); k++) begin
      checks++;
      if (obs_e[k] !== exp_e[k] || obs_i[k] !== exp_i[k] || obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_mid_out[%0d] got @%0d %0d/%0d want @%0d %0d/%0d", k, obs_e[k], obs_i[k], obs_q[k], exp_e[k], exp_i[k], exp_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_impulse();
    test_center();
    test_saturation();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
